// File: rtl/beta_control_sequencer.sv
// Multicycle control sequencer for the Beta datapath. Each instruction is
// fetched, decoded and walked through EXEC/MEM/WB. The block drives the
// datapath selects, the ALU function code and the write strobes, and it
// redirects to the illop or XAdr vectors on illegal opcodes, interrupts and
// ack timeouts.
module beta_control_sequencer #(
  parameter int         MEM_TIMEOUT = 255,
  parameter logic [3:0] ALUFN_ADD   = 4'h0,
  parameter logic [3:0] ALUFN_A     = 4'hA
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic [31:0] instr,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        z,
  input  logic        irq,
  input  logic        pc_super,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        ir_en,
  output logic        pc_en,
  output logic        werf,
  output logic        mwr,
  output logic        moe,
  output logic [2:0]  pcsel,
  output logic [1:0]  wdsel,
  output logic        asel,
  output logic        bsel,
  output logic        ra2sel,
  output logic        wasel,
  output logic [3:0]  alufn,
  output logic        busy
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [5:0] OP_LD  = 6'h18;
  localparam logic [5:0] OP_ST  = 6'h19;
  localparam logic [5:0] OP_JMP = 6'h1B;
  localparam logic [5:0] OP_BEQ = 6'h1C;
  localparam logic [5:0] OP_BNE = 6'h1D;
  localparam logic [5:0] OP_LDR = 6'h1F;

  // The counter holds the ack-less cycles seen before the current one, so the
  // wait gives up in the cycle that would make the count reach MEM_TIMEOUT.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0] r_state;
  logic [5:0] r_op;
  logic [7:0] r_cnt;
  logic       r_illop;
  logic       r_irq_trap;

  logic       w_is_mem;
  logic       w_legal;
  logic       w_ack;
  logic       w_timeout;
  logic       w_trap;
  logic [2:0] w_dec_pcsel;
  logic [1:0] w_dec_wdsel;
  logic       w_dec_asel;
  logic       w_dec_bsel;
  logic       w_dec_ra2sel;
  logic [3:0] w_dec_alufn;
  logic       w_unused_instr;

  // Only the opcode field is consumed here; the operand fields feed the datapath.
  assign w_unused_instr = ^instr[25:0];

  assign w_is_mem  = (r_op == OP_LD) || (r_op == OP_ST) || (r_op == OP_LDR);
  assign w_legal   = r_op[5] || w_is_mem || (r_op == OP_JMP) ||
                     (r_op == OP_BEQ) || (r_op == OP_BNE);
  assign w_ack     = (r_state == S_FETCH) ? imem_ack : dmem_ack;
  assign w_timeout = !w_ack && (r_cnt == TIMEOUT_LAST);
  assign w_trap    = r_illop || r_irq_trap;

  // Opcode decode: the datapath controls implied by the latched opcode.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_dec_pcsel  = 3'd0;
    w_dec_wdsel  = 2'd0;
    w_dec_asel   = 1'b0;
    w_dec_bsel   = 1'b0;
    w_dec_ra2sel = 1'b0;
    w_dec_alufn  = 4'h0;
    if (r_op[5]) begin
      w_dec_wdsel = 2'd1;
      w_dec_alufn = r_op[3:0];
      w_dec_bsel  = r_op[4];
    end else begin
      case (r_op)
        OP_LD:  begin w_dec_bsel = 1'b1; w_dec_alufn = ALUFN_ADD; w_dec_wdsel = 2'd2; end
        OP_ST:  begin w_dec_bsel = 1'b1; w_dec_ra2sel = 1'b1; w_dec_alufn = ALUFN_ADD; end
        OP_LDR: begin w_dec_asel = 1'b1; w_dec_alufn = ALUFN_A; w_dec_wdsel = 2'd2; end
        OP_JMP: w_dec_pcsel = 3'd2;
        OP_BEQ: w_dec_pcsel = z ? 3'd1 : 3'd0;
        OP_BNE: w_dec_pcsel = z ? 3'd0 : 3'd1;
        default: ;
      endcase
    end
  end

  // Sequencing: state, latched opcode, ack-wait counter and trap flags.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (RESET) begin
      r_state    <= S_FETCH;
      r_op       <= 6'h00;
      r_cnt      <= 8'd0;
      r_illop    <= 1'b0;
      r_irq_trap <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            r_op    <= instr[31:26];
            r_cnt   <= 8'd0;
            r_state <= S_DECODE;
          end else if (w_timeout) begin
            r_illop <= 1'b1;
            r_state <= S_WB;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          if (irq && !pc_super) begin
            r_irq_trap <= 1'b1;
            r_state    <= S_WB;
          end else if (!w_legal) begin
            r_illop <= 1'b1;
            r_state <= S_WB;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_cnt   <= 8'd0;
          r_state <= w_is_mem ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (dmem_ack) begin
            r_state <= S_WB;
          end else if (w_timeout) begin
            r_illop <= 1'b1;
            r_state <= S_WB;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_cnt      <= 8'd0;
          r_illop    <= 1'b0;
          r_irq_trap <= 1'b0;
          r_state    <= S_FETCH;
        end
      endcase
    end
  end

  // Output drive: strobes confined to their states, traps override in WB.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    ir_en    = 1'b0;
    pc_en    = 1'b0;
    werf     = 1'b0;
    mwr      = 1'b0;
    moe      = 1'b0;
    pcsel    = 3'd0;
    wdsel    = 2'd0;
    asel     = 1'b0;
    bsel     = 1'b0;
    ra2sel   = 1'b0;
    wasel    = 1'b0;
    alufn    = 4'h0;
    busy     = 1'b0;
    if (!RESET) begin
      busy = (r_state != S_FETCH);
      case (r_state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_en    = imem_ack;
        end
        S_DECODE, S_EXEC, S_MEM, S_WB: begin
          pcsel  = w_dec_pcsel;
          wdsel  = w_dec_wdsel;
          asel   = w_dec_asel;
          bsel   = w_dec_bsel;
          ra2sel = w_dec_ra2sel;
          alufn  = w_dec_alufn;
          if (r_state == S_MEM) begin
            dmem_req = 1'b1;
            moe      = (r_op == OP_LD) || (r_op == OP_LDR);
            mwr      = (r_op == OP_ST);
          end
          if (r_state == S_WB) begin
            pc_en = 1'b1;
            if (w_trap) begin
              pcsel  = r_irq_trap ? 3'd4 : 3'd3;
              wdsel  = 2'd0;
              wasel  = 1'b1;
              werf   = 1'b1;
              asel   = 1'b0;
              bsel   = 1'b0;
              ra2sel = 1'b0;
              alufn  = 4'h0;
            end else begin
              werf = (r_op != OP_ST);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_beta_control_sequencer.sv
// Self-checking bench for beta_control_sequencer. Each instruction is played
// as a transaction: the bench picks its opcode, ack delays, interrupt and z,
// derives the expected per-cycle outputs from the instruction-level rules,
// and a single compare process checks the DUT against them every cycle.
module tb_beta_control_sequencer;

  localparam int         TO     = 4;
  localparam logic [3:0] FN_ADD = 4'h0;
  localparam logic [3:0] FN_A   = 4'hA;

  localparam logic [5:0] OP_LD  = 6'h18;
  localparam logic [5:0] OP_ST  = 6'h19;
  localparam logic [5:0] OP_JMP = 6'h1B;
  localparam logic [5:0] OP_BEQ = 6'h1C;
  localparam logic [5:0] OP_BNE = 6'h1D;
  localparam logic [5:0] OP_LDR = 6'h1F;

  // Strobe vector bit masks: {imem_req,dmem_req,ir_en,pc_en,werf,mwr,moe,busy}
  localparam logic [7:0] M_IMEM = 8'h80;
  localparam logic [7:0] M_DREQ = 8'h40;
  localparam logic [7:0] M_IREN = 8'h20;
  localparam logic [7:0] M_PCEN = 8'h10;
  localparam logic [7:0] M_WERF = 8'h08;
  localparam logic [7:0] M_MWR  = 8'h04;
  localparam logic [7:0] M_MOE  = 8'h02;
  localparam logic [7:0] M_BUSY = 8'h01;

  typedef struct packed {
    logic [2:0] pcsel;
    logic [1:0] wdsel;
    logic       asel;
    logic       bsel;
    logic       ra2sel;
    logic       wasel;
    logic [3:0] alufn;
  } ctl_t;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] instr = '0;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0, z = 1'b0, irq = 1'b0, pc_super = 1'b0;
  logic        imem_req, dmem_req, ir_en, pc_en, werf, mwr, moe;
  logic [2:0]  pcsel;
  logic [1:0]  wdsel;
  logic        asel, bsel, ra2sel, wasel;
  logic [3:0]  alufn;
  logic        busy;

  int n_total = 0;
  int n_bad   = 0;

  // Expectation for the current cycle, written by the driver.
  logic       exp_valid = 1'b0;
  logic [7:0] exp_str = '0;
  logic [5:0] exp_sel = '0;
  logic [6:0] exp_dp = '0;
  logic       exp_chk_sel = 1'b0;
  logic       exp_chk_dp = 1'b0;

  // DUT observations for the literal checks.
  int          cyc, n_ir_en, n_mwr, n_dreq, n_pc_en, n_werf, pc_en_cyc;
  logic [31:0] wb_pcsel, wb_wdsel, wb_bsel, wb_wasel, wb_werf, wb_pc_en, wb_ra2sel;
  logic [31:0] last_all;

  beta_control_sequencer #(
    .MEM_TIMEOUT(TO),
    .ALUFN_ADD  (FN_ADD),
    .ALUFN_A    (FN_A)
  ) dut (
    .clk     (clk),
    .RESET   (RESET),
    .instr   (instr),
    .imem_ack(imem_ack),
    .dmem_ack(dmem_ack),
    .z       (z),
    .irq     (irq),
    .pc_super(pc_super),
    .imem_req(imem_req),
    .dmem_req(dmem_req),
    .ir_en   (ir_en),
    .pc_en   (pc_en),
    .werf    (werf),
    .mwr     (mwr),
    .moe     (moe),
    .pcsel   (pcsel),
    .wdsel   (wdsel),
    .asel    (asel),
    .bsel    (bsel),
    .ra2sel  (ra2sel),
    .wasel   (wasel),
    .alufn   (alufn),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
    end
  endtask

  // Reference decode table, stated per opcode.
  function automatic ctl_t decode(input logic [5:0] op, input logic zz);
    ctl_t c = '0;
    if (op >= 6'h20) begin
      c.wdsel = 2'd1;
      c.alufn = op[3:0];
      c.bsel  = (op >= 6'h30);
    end else if (op == OP_LD) begin
      c.bsel = 1'b1; c.alufn = FN_ADD; c.wdsel = 2'd2;
    end else if (op == OP_ST) begin
      c.bsel = 1'b1; c.ra2sel = 1'b1; c.alufn = FN_ADD;
    end else if (op == OP_LDR) begin
      c.asel = 1'b1; c.alufn = FN_A; c.wdsel = 2'd2;
    end else if (op == OP_JMP) begin
      c.pcsel = 3'd2;
    end else if (op == OP_BEQ) begin
      c.pcsel = zz ? 3'd1 : 3'd0;
    end else if (op == OP_BNE) begin
      c.pcsel = zz ? 3'd0 : 3'd1;
    end
    return c;
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return (op >= 6'h20) || (op inside {OP_LD, OP_ST, OP_LDR, OP_JMP, OP_BEQ, OP_BNE});
  endfunction

  function automatic logic is_mem(input logic [5:0] op);
    return op inside {OP_LD, OP_ST, OP_LDR};
  endfunction

  // Single compare process: outputs sampled on the falling edge.
  always @(negedge clk) begin
    if (exp_valid) begin
      check("strobes", 32'({imem_req, dmem_req, ir_en, pc_en, werf, mwr, moe, busy}), 32'(exp_str));
      if (exp_chk_sel) check("selects", 32'({pcsel, wdsel, wasel}), 32'(exp_sel));
      if (exp_chk_dp)  check("datapath", 32'({asel, bsel, ra2sel, alufn}), 32'(exp_dp));
    end
  end

  task automatic set_exp(input logic [7:0] str, input ctl_t c, input logic cs, input logic cd);
    exp_str     = str;
    exp_sel     = {c.pcsel, c.wdsel, c.wasel};
    exp_dp      = {c.asel, c.bsel, c.ra2sel, c.alufn};
    exp_chk_sel = cs;
    exp_chk_dp  = cd;
    exp_valid   = 1'b1;
  endtask

  // Start a cycle: inputs irrelevant to the current step get random values.
  task automatic next_cycle(input int zmode);
    @(posedge clk);
    #1;
    RESET    = 1'b0;
    instr    = $urandom;
    imem_ack = 1'($urandom);
    dmem_ack = 1'($urandom);
    irq      = 1'($urandom);
    pc_super = 1'($urandom);
    z        = (zmode < 2) ? (zmode == 1) : 1'($urandom);
  endtask

  task automatic finish_cycle(input logic is_wb);
    @(negedge clk);
    cyc++;
    if (ir_en) n_ir_en++;
    if (mwr) n_mwr++;
    if (dmem_req) n_dreq++;
    if (werf) n_werf++;
    if (pc_en) begin
      n_pc_en++;
      if (pc_en_cyc == 0) pc_en_cyc = cyc;
    end
    last_all = 32'({imem_req, dmem_req, ir_en, pc_en, werf, mwr, moe, pcsel, wdsel,
                    asel, bsel, ra2sel, wasel, alufn, busy});
    if (is_wb) begin
      wb_pcsel  = 32'(pcsel);
      wb_wdsel  = 32'(wdsel);
      wb_bsel   = 32'(bsel);
      wb_wasel  = 32'(wasel);
      wb_werf   = 32'(werf);
      wb_pc_en  = 32'(pc_en);
      wb_ra2sel = 32'(ra2sel);
    end
  endtask

  task automatic clear_obs();
    cyc = 0; n_ir_en = 0; n_mwr = 0; n_dreq = 0; n_pc_en = 0; n_werf = 0; pc_en_cyc = 0;
    wb_pcsel = '1; wb_wdsel = '1; wb_bsel = '1; wb_wasel = '1;
    wb_werf = '1; wb_pc_en = '1; wb_ra2sel = '1;
  endtask

  task automatic reset_cycle();
    next_cycle(2);
    RESET = 1'b1;
    set_exp(8'h00, '0, 1'b1, 1'b1);
    finish_cycle(1'b0);
  endtask

  // One instruction as a transaction. fwait/dwait: index of the ack cycle
  // (>= TO means no ack). zmode 0/1 forces z, 2 randomises it. mem_rst >= 0
  // asserts RESET in that MEM cycle and abandons the instruction.
  task automatic run_instr(input logic [5:0] op, input int fwait, input logic irqd,
                           input logic psup, input int dwait, input int zmode, input int mem_rst);
    logic t_irq, t_ill, fetched, done;
    ctl_t c;
    t_irq = 1'b0; t_ill = 1'b0; fetched = 1'b0; done = 1'b0;
    clear_obs();
    for (int k = 0; k < TO && !fetched && !t_ill; k++) begin
      next_cycle(zmode);
      imem_ack = (k == fwait);
      if (imem_ack) begin
        instr   = {op, 26'($urandom)};
        fetched = 1'b1;
      end else if (k == TO - 1) begin
        t_ill = 1'b1;
      end
      set_exp(M_IMEM | (imem_ack ? M_IREN : 8'h00), '0, 1'b0, 1'b0);
      finish_cycle(1'b0);
    end
    if (fetched) begin
      next_cycle(zmode);
      irq      = irqd;
      pc_super = psup;
      t_irq    = irqd && !psup;
      set_exp(M_BUSY, decode(op, z), !t_irq, !t_irq);
      finish_cycle(1'b0);
      if (!t_irq && !is_legal(op)) t_ill = 1'b1;
      if (!t_irq && !t_ill) begin
        next_cycle(zmode);
        set_exp(M_BUSY, decode(op, z), 1'b1, 1'b1);
        finish_cycle(1'b0);
        if (is_mem(op)) begin
          for (int k = 0; k < TO && !done && !t_ill; k++) begin
            next_cycle(zmode);
            if (k == mem_rst) begin
              RESET    = 1'b1;
              dmem_ack = 1'b1;
              set_exp(8'h00, '0, 1'b1, 1'b1);
              finish_cycle(1'b0);
              return;
            end
            dmem_ack = (k == dwait);
            set_exp(M_DREQ | M_BUSY | ((op == OP_ST) ? M_MWR : M_MOE), decode(op, z), 1'b1, 1'b1);
            finish_cycle(1'b0);
            if (dmem_ack) done = 1'b1;
            else if (k == TO - 1) t_ill = 1'b1;
          end
        end
      end
    end
    next_cycle(zmode);
    if (t_irq || t_ill) begin
      c = '0;
      c.pcsel = t_irq ? 3'd4 : 3'd3;
      c.wasel = 1'b1;
      set_exp(M_PCEN | M_WERF | M_BUSY, c, 1'b1, 1'b0);
    end else begin
      set_exp(M_PCEN | M_BUSY | ((op != OP_ST) ? M_WERF : 8'h00), decode(op, z), 1'b1, 1'b1);
    end
    finish_cycle(1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [5:0] op;
    logic [5:0] specials [6];
    int         sel, mrst;
    specials = '{OP_LD, OP_ST, OP_JMP, OP_BEQ, OP_BNE, OP_LDR};

    clear_obs();
    reset_cycle();
    reset_cycle();
    check("reset_all_outputs_zero", last_all, 32'h0);

    // ADDC, fetch ack on the second FETCH cycle.
    run_instr(6'h30, 1, 1'b0, 1'b0, 0, 2, -1);
    check("addc_ir_en_pulses", 32'(n_ir_en), 32'd1);
    check("addc_pc_en_cycle", 32'(pc_en_cyc), 32'd5);
    check("addc_wb_bsel", wb_bsel, 32'd1);
    check("addc_wb_wdsel", wb_wdsel, 32'd1);
    check("addc_wb_werf", wb_werf, 32'd1);
    check("addc_wb_pcsel", wb_pcsel, 32'd0);

    // ST with dmem_ack on the third MEM cycle.
    run_instr(OP_ST, 0, 1'b0, 1'b0, 2, 2, -1);
    check("st_mwr_cycles", 32'(n_mwr), 32'd3);
    check("st_dreq_cycles", 32'(n_dreq), 32'd3);
    check("st_wb_werf", wb_werf, 32'd0);
    check("st_wb_pc_en", wb_pc_en, 32'd1);
    check("st_wb_ra2sel", wb_ra2sel, 32'd1);

    // Branches with z=1.
    run_instr(OP_BEQ, 0, 1'b0, 1'b0, 0, 1, -1);
    check("beq_z1_pcsel", wb_pcsel, 32'd1);
    check("beq_wdsel", wb_wdsel, 32'd0);
    run_instr(OP_BNE, 0, 1'b0, 1'b0, 0, 1, -1);
    check("bne_z1_pcsel", wb_pcsel, 32'd0);
    check("bne_werf", wb_werf, 32'd1);

    // Illegal opcode, interrupt trap, supervisor-masked interrupt.
    run_instr(6'h00, 0, 1'b0, 1'b0, 0, 2, -1);
    check("illop_pcsel", wb_pcsel, 32'd3);
    check("illop_wasel", wb_wasel, 32'd1);
    check("illop_werf", wb_werf, 32'd1);
    run_instr(6'h30, 0, 1'b1, 1'b0, 0, 2, -1);
    check("irq_pcsel", wb_pcsel, 32'd4);
    run_instr(6'h30, 0, 1'b1, 1'b1, 0, 2, -1);
    check("irq_super_pcsel", wb_pcsel, 32'd0);
    check("irq_super_wdsel", wb_wdsel, 32'd1);
    check("irq_super_wasel", wb_wasel, 32'd0);

    // Memory timeout, and an ack landing in the timeout cycle.
    run_instr(OP_LD, 0, 1'b0, 1'b0, 99, 2, -1);
    check("ld_timeout_dreq_cycles", 32'(n_dreq), 32'd4);
    check("ld_timeout_pcsel", wb_pcsel, 32'd3);
    run_instr(OP_LD, 0, 1'b0, 1'b0, 3, 2, -1);
    check("ld_late_ack_dreq_cycles", 32'(n_dreq), 32'd4);
    check("ld_late_ack_pcsel", wb_pcsel, 32'd0);
    check("ld_late_ack_wdsel", wb_wdsel, 32'd2);
    run_instr(OP_ST, 0, 1'b0, 1'b0, 99, 2, -1);
    check("st_timeout_mwr_cycles", 32'(n_mwr), 32'd4);
    run_instr(6'h30, 99, 1'b0, 1'b0, 0, 2, -1);
    check("fetch_timeout_ir_en", 32'(n_ir_en), 32'd0);
    check("fetch_timeout_pcsel", wb_pcsel, 32'd3);

    // RESET in the second MEM cycle, with an ack pending.
    run_instr(OP_LD, 0, 1'b0, 1'b0, 99, 2, 1);
    check("rst_mem_outputs_zero", last_all, 32'h0);
    check("rst_mem_no_pc_en", 32'(n_pc_en), 32'd0);
    check("rst_mem_no_werf", 32'(n_werf), 32'd0);
    run_instr(6'h21, 0, 1'b0, 1'b0, 0, 2, -1);
    check("after_rst_pc_en_cycle", 32'(pc_en_cyc), 32'd4);

    // Randomised instruction stream.
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0)      op = specials[$urandom_range(0, 5)];
      else if (sel == 1) op = 6'h20 | 6'($urandom_range(0, 31));
      else               op = 6'($urandom);
      mrst = ($urandom_range(0, 15) == 0) ? $urandom_range(0, TO - 1) : -1;
      run_instr(op, $urandom_range(0, TO), ($urandom_range(0, 3) == 0), 1'($urandom),
                $urandom_range(0, TO), 2, mrst);
    end

    exp_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
